rr_onehot_grant: RTL and testbench
==================================

Name: rr_onehot_grant

Overview:
- Sequential round-robin arbiter that produces a registered one-hot grant vector from an N-bit request vector.
- Acts as the producer side of the team's one-hot interface. Its grant output is what the existing one-hot checker consumes: it must be zero or exactly one bit set.
- Sits between N requesters and one shared resource. It holds each grant until the owner signals completion.

Parameters:
- N, 8, number of requesters and width of the grant vector (N >= 2)
- IW, $clog2(N), width of the binary grant index (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester request, level-sensitive
- done  input  1  current owner releases the resource; ignored when no grant is active
- grant  output  N  registered one-hot grant; all zero when idle
- grant_valid  output  1  high when grant is non-zero
- grant_idx  output  IW  binary index of the granted bit; 0 when idle
- err  output  1  present only with ONEHOT_ERR_EN (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high):
  - grant=0, grant_valid=0, grant_idx=0.
  - Priority pointer ptr=0. State=IDLE.
  - Reset mid-grant drops the grant on the next edge; no release cycle is needed.
- States: IDLE, BUSY.
- Arbitration function pick(req, ptr):
  - Returns the first set bit of req scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Wraps modulo N.
  - Returns "none" if req==0.
- IDLE:
  - If req!=0: on the next edge, grant=onehot(pick), grant_idx=pick, grant_valid=1, state→BUSY.
  - Otherwise stay in IDLE with outputs zero.
  - Latency is 1 cycle from req to grant.
- BUSY:
  - Grant is held stable while done=0 and req[grant_idx]=1.
  - Release occurs when done=1, or when req[grant_idx]=0 (abandon). Both in the same cycle count as one release.
  - On release, ptr←(grant_idx+1) mod N.
  - Arbitration in the release cycle uses the new ptr and req with bit grant_idx masked off.
    - If another request wins, its grant appears on the next edge (back-to-back, no idle cycle); stay in BUSY.
    - If none wins, grant=0 on the next edge; state→IDLE.
- ptr changes only on release; it is never updated in IDLE.
- Fairness: with all N requesting continuously and done pulsed each grant, grants rotate 0,1,…,N-1,0.
- Wrap-around: owner N-1 releases → ptr=0.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant_valid == |grant.
  - grant_idx matches grant.
- done while in IDLE has no effect.

Optional Feature:
- Macro: RR_ONEHOT_ERR_EN.
- Defined:
  - Adds the err output port.
  - err is sticky: it sets on any cycle where grant is non-zero and not one-hot, or where grant_valid disagrees with grant.
  - err clears only on rst. Reset value 0.
- Undefined:
  - No err port and no checking logic.
  - Functional behaviour is otherwise identical.

Decomposition:
- Shared package rr_onehot_pkg holds:
  - the state enum (IDLE, BUSY)
  - the default N constant
  - a onehot-from-index function
- Natural sub-module: rr_pick.
  - Combinational rotate-priority picker.
  - Inputs: req, ptr, mask.
  - Outputs: found and idx.
  - Implemented by double-width concatenation and shift.

Test Plan:
- rst=1 for 2 cycles, req=8'hFF → grant=0, grant_valid=0, grant_idx=0 throughout reset; first grant 8'h01 one cycle after rst falls.
- req=8'h00 then req=8'b0001_0000 → grant=8'b0001_0000, grant_idx=4 after 1 cycle; hold 5 cycles with done=0; grant unchanged.
- req=8'hFF held, done pulsed every 3rd cycle → grant sequence 01,02,04,…,80,01 with no idle cycles between grants.
- Owner 7 granted with req=8'b1000_0001, done=1 → next grant=8'h01 (wrap, ptr=0); then release with req=0 → grant=0, state IDLE.
- Owner 2 granted, req[2] dropped with done=0 and req=8'b0010_0000 → next edge grant=8'b0010_0000 (abandon treated as release).
- Assert rst while grant=8'h08 → grant=0 on next edge; after rst falls, req=8'h0C → grant=8'h04 (ptr reset to 0). With RR_ONEHOT_ERR_EN, err=0 for all scenarios.

Source files
------------

// File: rtl/rr_onehot_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package rr_onehot_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned N_DEFAULT = 8;
    localparam int unsigned N_MAX     = 256;

    // Callers narrow the result to their own width with a size cast.
    function automatic logic [N_MAX-1:0] onehot_from_idx(input logic [31:0] idx);
        return {{(N_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_onehot_grant_pick.sv
// Rotate-priority picker: first set bit of (req & ~mask) scanning from ptr upward, wrapping modulo N.
module rr_pick
    import rr_onehot_pkg::*;
#(
    parameter  int unsigned N  = N_DEFAULT,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic [N-1:0]  i_mask,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [N-1:0]   w_req;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_off;
    logic [IW:0]    w_sum;

    assign w_req = i_req & ~i_mask;
    // Shifting the doubled vector puts bit ptr at position 0 with wrap-around above it.
    assign w_dbl = {w_req, w_req} >> i_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_off   = '0;
        o_found = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (w_rot[i-1]) begin
                w_off   = (IW+1)'(i - 1);
                o_found = 1'b1;
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + w_off;
    assign o_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);

endmodule

// File: rtl/rr_onehot_grant.sv
// Round-robin arbiter with a registered one-hot grant held until done or abandon.
// Optional sticky one-hot integrity flag `err` when RR_ONEHOT_ERR_EN is defined.
module rr_onehot_grant
    import rr_onehot_pkg::*;
#(
    parameter  int unsigned N  = N_DEFAULT,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
`ifdef RR_ONEHOT_ERR_EN
    ,
    output logic          err
`endif
);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_grant;
    logic          r_valid;

    logic          w_release;
    logic          w_found;
    logic [IW-1:0] w_pick_idx;
    logic [IW-1:0] w_pick_ptr;
    logic [IW-1:0] w_next_ptr;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_pick_oh;

    assign w_release  = (r_state == BUSY) && (done || !req[r_idx]);
    assign w_next_ptr = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
    // The release cycle arbitrates with the advanced pointer and the owner masked off.
    assign w_pick_ptr = w_release ? w_next_ptr : r_ptr;
    assign w_mask     = (r_state == BUSY) ? N'(onehot_from_idx(32'(r_idx))) : '0;
    assign w_pick_oh  = N'(onehot_from_idx(32'(w_pick_idx)));

    rr_pick #(.N(N)) u_pick (
        .i_req   (req),
        .i_ptr   (w_pick_ptr),
        .i_mask  (w_mask),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick_oh;
                        r_idx   <= w_pick_idx;
                        r_valid <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_found) begin
                            r_grant <= w_pick_oh;
                            r_idx   <= w_pick_idx;
                        end else begin
                            r_grant <= '0;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;

`ifdef RR_ONEHOT_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (((r_grant & (r_grant - 1'b1)) != '0) || (r_valid != (|r_grant))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_rr_onehot_grant.sv
// Directed plus randomized bench for rr_onehot_grant against a queue-free behavioural arbiter model.
module tb_rr_onehot_grant;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          done = 1'b0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
`ifdef RR_ONEHOT_ERR_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 when idle) and priority pointer.
    int m_owner = -1;
    int m_ptr   = 0;

    rr_onehot_grant #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
`ifdef RR_ONEHOT_ERR_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] r;
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(req, m_ptr);
        end else if (done || !req[m_owner]) begin
            m_ptr = (m_owner + 1) % N;
            r = req;
            r[m_owner] = 1'b0;
            m_owner = pick(r, m_ptr);
        end
        #1;
        chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("grant_valid", 32'(grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
        chk("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
`ifdef RR_ONEHOT_ERR_EN
        chk("err", 32'(err), 32'd0);
`endif
    endtask

    initial begin
        // Reset with all requesting; first grant one cycle after release of reset.
        rst = 1'b1; req = 8'hFF; done = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("first_grant", 32'(grant), 32'h01);

        // Single requester 4, held for five cycles.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h00; step();
        req = 8'b0001_0000; step();
        chk("req4_grant", 32'(grant), 32'h10);
        chk("req4_idx", 32'(grant_idx), 32'd4);
        for (int i = 0; i < 5; i++) step();
        chk("req4_hold", 32'(grant), 32'h10);

        // Fair rotation with all requesting and done every third cycle.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'hFF; step();
        chk("rot_start", 32'(grant), 32'h01);
        for (int i = 0; i < 9; i++) begin
            done = 1'b0; step(); step();
            done = 1'b1; step();
            done = 1'b0;
            chk("rotation", 32'(grant), 32'd1 << ((i + 1) % N));
        end

        // Owner 7 wraps pointer to 0, then abandon with no requests goes idle.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h80; step();
        chk("owner7", 32'(grant), 32'h80);
        req = 8'b1000_0001; done = 1'b1; step();
        done = 1'b0;
        chk("wrap", 32'(grant), 32'h01);
        req = 8'h00; step();
        chk("idle_after_release", 32'(grant), 32'h00);
        done = 1'b1; step(); done = 1'b0;
        chk("done_in_idle", 32'(grant_valid), 32'd0);

        // Abandon by owner 2 hands over back-to-back.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h04; step();
        chk("owner2", 32'(grant), 32'h04);
        req = 8'b0010_0000; step();
        chk("abandon", 32'(grant), 32'h20);

        // Reset mid-grant, then pointer starts from 0 again.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h08; step();
        chk("owner3", 32'(grant), 32'h08);
        rst = 1'b1; step();
        chk("rst_mid_grant", 32'(grant), 32'h00);
        rst = 1'b0; req = 8'h0C; step();
        chk("ptr_after_rst", 32'(grant), 32'h04);

        // Randomized traffic; requests change only occasionally so grants persist.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 80) == 0);
            step();
        end
        rst = 1'b0; done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
